// File: rtl/sensor_display_sched.sv
// sensor_display_sched
// Keeps the latest sample of each sensor/timer channel, drives the FND data
// path with the selected channel (manual stepping or timed auto-rotation),
// and serialises fresh samples into a valid/ready report stream.
// Optional build macro: SENSOR_SCHED_STALE_EN adds per-channel staleness
// tracking; without it disp_stale is tied to 0.
//
// Report handshake: rep_valid rises only with rep_ch/rep_data already loaded,
// and those three stay frozen until the cycle in which rep_valid && rep_ready
// is seen at a rising clk edge. rep_valid never drops without that handshake,
// except through reset.
module sensor_display_sched #(
    parameter int N_CH        = 4,
    parameter int DATA_W      = 32,
    parameter int DWELL_TICKS = 3000,
    parameter int STALE_TICKS = 5000,
    parameter int CH_W        = $clog2(N_CH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   tick,
    input  logic [N_CH*DATA_W-1:0] ch_data,
    input  logic [N_CH-1:0]        ch_valid,
    input  logic [N_CH-1:0]        ch_en,
    input  logic                   auto_mode,
    input  logic                   btn_next,
    input  logic                   btn_prev,
    output logic [DATA_W-1:0]      disp_data,
    output logic [CH_W-1:0]        disp_ch,
    output logic                   disp_stale,
    output logic                   rep_valid,
    output logic [CH_W-1:0]        rep_ch,
    output logic [DATA_W-1:0]      rep_data,
    input  logic                   rep_ready,
    output logic                   rep_state_dbg
);

    localparam int DWELL_W = (DWELL_TICKS > 2) ? $clog2(DWELL_TICKS) : 1;
    localparam int STALE_W = $clog2(STALE_TICKS + 1);

    // Parameter range guard, evaluated at elaboration only.
    if (N_CH < 2 || N_CH > 16 || DWELL_TICKS < 2 || STALE_TICKS < 2) begin : g_bad_param
        $error("sensor_display_sched: parameter out of range");
    end

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } rep_state_e;

    // Channel index 'off' positions above 'base', modulo N_CH.
    function automatic logic [CH_W-1:0] idx_fwd(input logic [CH_W-1:0] base, input int off);
        int v;
        v = (int'(base) + off) % N_CH;
        return CH_W'(v);
    endfunction

    // Channel index 'off' positions below 'base', modulo N_CH (off <= N_CH).
    function automatic logic [CH_W-1:0] idx_bwd(input logic [CH_W-1:0] base, input int off);
        int v;
        v = (int'(base) + N_CH - off) % N_CH;
        return CH_W'(v);
    endfunction

    // Sample store and pending flags
    logic [DATA_W-1:0]  samp_q [N_CH];
    logic [DATA_W-1:0]  samp_d [N_CH];
    logic [N_CH-1:0]    pend_q, pend_d;

    // Display selection
    logic [CH_W-1:0]    cur_q, cur_d;
    logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
    logic [CH_W-1:0]    nxt_ch, prv_ch;
    logic               move_btn, dwell_end;
    logic [DATA_W-1:0]  disp_data_q, disp_data_d;
    logic [CH_W-1:0]    disp_ch_q, disp_ch_d;

    // Report path
    rep_state_e         state_q, state_d;
    logic [N_CH-1:0]    eligible;
    logic [CH_W-1:0]    grant_ch;
    logic               grant_load;
    logic               rep_valid_c;
    logic [CH_W-1:0]    last_q, last_d;
    logic [CH_W-1:0]    rep_ch_q, rep_ch_d;
    logic [DATA_W-1:0]  rep_data_q, rep_data_d;

    // Nearest enabled channel above and below cur; holds cur if none enabled.
    always_comb begin
        nxt_ch = cur_q;
        prv_ch = cur_q;
        for (int i = N_CH; i >= 1; i--) begin
            if (ch_en[idx_fwd(cur_q, i)]) nxt_ch = idx_fwd(cur_q, i);
            if (ch_en[idx_bwd(cur_q, i)]) prv_ch = idx_bwd(cur_q, i);
        end
    end

    // Sample capture; a fresh sample wins over a same-cycle grant clear, and
    // disabled channels never keep a pending record.
    always_comb begin
        samp_d = samp_q;
        pend_d = pend_q;
        for (int k = 0; k < N_CH; k++) begin
            if (ch_valid[k]) samp_d[k] = ch_data[k*DATA_W +: DATA_W];
            if (grant_load && (grant_ch == CH_W'(k))) pend_d[k] = 1'b0;
            if (ch_valid[k]) pend_d[k] = 1'b1;
            if (!ch_en[k]) pend_d[k] = 1'b0;
        end
    end

    // Sample store registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < N_CH; k++) samp_q[k] <= '0;
            pend_q <= '0;
        end else begin
            samp_q <= samp_d;
            pend_q <= pend_d;
        end
    end

    // Channel selection: forced hop off a disabled channel, then a single
    // button, then dwell expiry. Dwell only runs in auto mode.
    always_comb begin
        move_btn  = btn_next ^ btn_prev;
        dwell_end = auto_mode && tick && (dwell_cnt_q >= DWELL_W'(DWELL_TICKS - 1));

        dwell_cnt_d = dwell_cnt_q;
        if (!auto_mode || move_btn) begin
            dwell_cnt_d = '0;
        end else if (tick) begin
            if (dwell_cnt_q >= DWELL_W'(DWELL_TICKS - 1)) dwell_cnt_d = '0;
            else                                          dwell_cnt_d = dwell_cnt_q + 1'b1;
        end

        cur_d = cur_q;
        if (!ch_en[cur_q])              cur_d = nxt_ch;
        else if (btn_next && !btn_prev) cur_d = nxt_ch;
        else if (btn_prev && !btn_next) cur_d = prv_ch;
        else if (dwell_end)             cur_d = nxt_ch;

        disp_data_d = samp_q[cur_q];
        disp_ch_d   = cur_q;
    end

    // Selection and display registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            cur_q       <= '0;
            dwell_cnt_q <= '0;
            disp_data_q <= '0;
            disp_ch_q   <= '0;
        end else begin
            cur_q       <= cur_d;
            dwell_cnt_q <= dwell_cnt_d;
            disp_data_q <= disp_data_d;
            disp_ch_q   <= disp_ch_d;
        end
    end

    assign disp_data = disp_data_q;
    assign disp_ch   = disp_ch_q;

`ifdef SENSOR_SCHED_STALE_EN
    logic [STALE_W-1:0] stale_cnt_q [N_CH];
    logic [STALE_W-1:0] stale_cnt_d [N_CH];
    logic [N_CH-1:0]    stale_q, stale_d;
    logic               disp_stale_q, disp_stale_d;

    // Ticks since each channel's last sample, saturating at STALE_TICKS.
    always_comb begin
        stale_cnt_d = stale_cnt_q;
        stale_d     = stale_q;
        for (int k = 0; k < N_CH; k++) begin
            if (ch_valid[k]) begin
                stale_cnt_d[k] = '0;
                stale_d[k]     = 1'b0;
            end else if (tick && (stale_cnt_q[k] < STALE_W'(STALE_TICKS))) begin
                stale_cnt_d[k] = stale_cnt_q[k] + 1'b1;
                if (stale_cnt_q[k] == STALE_W'(STALE_TICKS - 1)) stale_d[k] = 1'b1;
            end
        end
        disp_stale_d = stale_q[cur_q];
    end

    // Staleness registers; every channel counts as stale until first sampled.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < N_CH; k++) stale_cnt_q[k] <= '0;
            stale_q      <= '1;
            disp_stale_q <= 1'b1;
        end else begin
            stale_cnt_q  <= stale_cnt_d;
            stale_q      <= stale_d;
            disp_stale_q <= disp_stale_d;
        end
    end

    assign disp_stale = disp_stale_q;
`else
    assign disp_stale = 1'b0;
`endif

    // Round-robin grant among enabled pending channels, starting after last.
    always_comb begin
        eligible = pend_q & ch_en;
        grant_ch = last_q;
        for (int i = N_CH; i >= 1; i--) begin
            if (eligible[idx_fwd(last_q, i)]) grant_ch = idx_fwd(last_q, i);
        end
    end

    // Report FSM state register
    always_ff @(posedge clk) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    // Report FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (|eligible) state_d = ST_SEND;
            ST_SEND: if (rep_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Report FSM outputs
    always_comb begin
        rep_valid_c = 1'b0;
        grant_load  = 1'b0;
        case (state_q)
            ST_IDLE: grant_load  = |eligible;
            ST_SEND: rep_valid_c = 1'b1;
            default: ;
        endcase
    end

    // Record payload; loaded from the stored sample at grant, frozen in SEND.
    always_comb begin
        rep_ch_d   = rep_ch_q;
        rep_data_d = rep_data_q;
        last_d     = last_q;
        if (grant_load) begin
            rep_ch_d   = grant_ch;
            rep_data_d = samp_q[grant_ch];
            last_d     = grant_ch;
        end
    end

    // Record payload registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            rep_ch_q   <= '0;
            rep_data_q <= '0;
            last_q     <= '0;
        end else begin
            rep_ch_q   <= rep_ch_d;
            rep_data_q <= rep_data_d;
            last_q     <= last_d;
        end
    end

    assign rep_valid     = rep_valid_c;
    assign rep_ch        = rep_ch_q;
    assign rep_data      = rep_data_q;
    assign rep_state_dbg = (state_q == ST_SEND);

endmodule

// File: tb/tb_sensor_display_sched.sv
// Bench for sensor_display_sched: directed steps followed by randomized
// bursts, checked against a transaction-level model (round-robin order
// queue, nearest-enabled channel search, tick counting).
`timescale 1ns/1ps
module tb_sensor_display_sched;

    localparam int N_CH        = 4;
    localparam int DATA_W      = 32;
    localparam int DWELL_TICKS = 4;
    localparam int STALE_TICKS = 3;
    localparam int CH_W        = 2;
    localparam int REC_W       = CH_W + DATA_W;
`ifdef SENSOR_SCHED_STALE_EN
    localparam logic STALE_ON = 1'b1;
`else
    localparam logic STALE_ON = 1'b0;
`endif

    logic                   clk;
    logic                   rst;
    logic                   tick;
    logic [N_CH*DATA_W-1:0] ch_data;
    logic [N_CH-1:0]        ch_valid;
    logic [N_CH-1:0]        ch_en;
    logic                   auto_mode;
    logic                   btn_next;
    logic                   btn_prev;
    logic [DATA_W-1:0]      disp_data;
    logic [CH_W-1:0]        disp_ch;
    logic                   disp_stale;
    logic                   rep_valid;
    logic [CH_W-1:0]        rep_ch;
    logic [DATA_W-1:0]      rep_data;
    logic                   rep_ready;
    logic                   rep_state_dbg;

    sensor_display_sched #(
        .N_CH(N_CH), .DATA_W(DATA_W), .DWELL_TICKS(DWELL_TICKS),
        .STALE_TICKS(STALE_TICKS), .CH_W(CH_W)
    ) dut (
        .clk(clk), .rst(rst), .tick(tick), .ch_data(ch_data),
        .ch_valid(ch_valid), .ch_en(ch_en), .auto_mode(auto_mode),
        .btn_next(btn_next), .btn_prev(btn_prev), .disp_data(disp_data),
        .disp_ch(disp_ch), .disp_stale(disp_stale), .rep_valid(rep_valid),
        .rep_ch(rep_ch), .rep_data(rep_data), .rep_ready(rep_ready),
        .rep_state_dbg(rep_state_dbg)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300us;
        $display("FAIL watchdog: observed no end of test, expected end before 300us");
        $fatal(1, "watchdog expired");
    end

    int n_assert = 0;
    int n_fail   = 0;

    // Model state
    int                m_cur;
    int                m_last;
    int                m_dwell;
    logic [DATA_W-1:0] m_samp [N_CH];
    logic [DATA_W-1:0] drv    [N_CH];
    logic [REC_W-1:0]  exp_q  [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int nxt_of(input int c, input logic [N_CH-1:0] en);
        for (int d = 1; d <= N_CH; d++) if (en[(c + d) % N_CH]) return (c + d) % N_CH;
        return c;
    endfunction

    function automatic int prv_of(input int c, input logic [N_CH-1:0] en);
        for (int d = 1; d <= N_CH; d++) if (en[(c + N_CH - d) % N_CH]) return (c + N_CH - d) % N_CH;
        return c;
    endfunction

    // Driver: one-cycle button pulse, then one more cycle for the display register.
    task automatic pulse_btn(input logic nx, input logic pv);
        if (!ch_en[m_cur])     m_cur = nxt_of(m_cur, ch_en);
        else if (nx && !pv)    m_cur = nxt_of(m_cur, ch_en);
        else if (pv && !nx)    m_cur = prv_of(m_cur, ch_en);
        if (auto_mode && (nx ^ pv)) m_dwell = 0;
        btn_next = nx;
        btn_prev = pv;
        step();
        btn_next = 1'b0;
        btn_prev = 1'b0;
        step();
    endtask

    // Driver: one tick, then 9 quiet cycles.
    task automatic tick_pulse();
        if (auto_mode) begin
            if (m_dwell == DWELL_TICKS - 1) begin
                m_dwell = 0;
                m_cur   = nxt_of(m_cur, ch_en);
            end else begin
                m_dwell++;
            end
        end
        tick = 1'b1;
        step();
        tick = 1'b0;
        repeat (9) step();
    endtask

    // Driver: one-cycle sample strobe on the channels in mask using drv[].
    task automatic send(input logic [N_CH-1:0] mask);
        for (int k = 0; k < N_CH; k++) begin
            if (mask[k]) begin
                ch_data[k*DATA_W +: DATA_W] = drv[k];
                m_samp[k] = drv[k];
            end
        end
        ch_valid = mask;
        step();
        ch_valid = '0;
    endtask

    // Driver + model: burst from an idle, drained scheduler; the records come
    // out in round-robin order starting after the last reported channel.
    task automatic send_burst(input logic [N_CH-1:0] mask);
        for (int d = 1; d <= N_CH; d++) begin
            if (mask[(m_last + d) % N_CH]) exp_q.push_back({CH_W'((m_last + d) % N_CH), drv[(m_last + d) % N_CH]});
        end
        send(mask);
    endtask

    // Scoreboard: accept one record with ready high, compare with queue head.
    task automatic recv(input string tag, output int w);
        logic [REC_W-1:0] rec;
        rep_ready = 1'b1;
        w = 0;
        while (!rep_valid && w < 20) begin
            step();
            w++;
        end
        chk({tag, "_valid"}, 64'(rep_valid), 64'd1);
        rec = '0;
        if (exp_q.size() > 0) rec = exp_q.pop_front();
        chk({tag, "_rec"}, 64'({rep_ch, rep_data}), 64'(rec));
        m_last = int'(rec[REC_W-1:DATA_W]);
        step();
    endtask

    initial begin
        int               w;
        int               cyc;
        logic             held;
        logic [REC_W-1:0] hold_rec;
        logic [REC_W-1:0] rec;
        logic [N_CH-1:0]  mask;
        logic [1:0]       b;

        // Reset
        rst = 1'b0; tick = 1'b0; ch_data = '0; ch_valid = '0; ch_en = 4'b1111;
        auto_mode = 1'b0; btn_next = 1'b0; btn_prev = 1'b0; rep_ready = 1'b0;
        m_cur = 0; m_last = 0; m_dwell = 0;
        for (int k = 0; k < N_CH; k++) begin m_samp[k] = '0; drv[k] = '0; end
        repeat (3) step();
        rst = 1'b1;
        chk("rst_disp_data", 64'(disp_data), 64'd0);
        chk("rst_disp_ch", 64'(disp_ch), 64'd0);
        chk("rst_disp_stale", 64'(disp_stale), 64'(STALE_ON));
        chk("rst_rep_valid", 64'(rep_valid), 64'd0);
        chk("rst_rep_ch", 64'(rep_ch), 64'd0);
        chk("rst_rep_data", 64'(rep_data), 64'd0);
        chk("rst_state", 64'(rep_state_dbg), 64'd0);

        // Manual stepping through all four channels and wrap
        for (int i = 0; i < 4; i++) begin
            pulse_btn(1'b1, 1'b0);
            chk("btn_next_seq", 64'(disp_ch), 64'(m_cur));
        end

        // Sparse enable mask: forced hop, next, prev, both buttons
        ch_en = 4'b1010;
        pulse_btn(1'b0, 1'b0);
        chk("hop_to_1", 64'(disp_ch), 64'(m_cur));
        pulse_btn(1'b1, 1'b0);
        chk("sparse_next", 64'(disp_ch), 64'(m_cur));
        pulse_btn(1'b0, 1'b1);
        chk("sparse_prev", 64'(disp_ch), 64'(m_cur));
        pulse_btn(1'b1, 1'b1);
        chk("both_btn_hold", 64'(disp_ch), 64'(m_cur));

        // Auto rotation, with a button restarting the dwell count
        ch_en = 4'b1111;
        auto_mode = 1'b1;
        m_dwell = 0;
        for (int i = 0; i < 4; i++) begin
            tick_pulse();
            chk("auto_dwell", 64'(disp_ch), 64'(m_cur));
        end
        tick_pulse();
        tick_pulse();
        pulse_btn(1'b1, 1'b0);
        chk("auto_btn", 64'(disp_ch), 64'(m_cur));
        for (int i = 0; i < 4; i++) begin
            tick_pulse();
            chk("auto_restart", 64'(disp_ch), 64'(m_cur));
        end
        auto_mode = 1'b0;

        // Single record: latency t+2
        drv[3] = 32'h3C;
        send_burst(4'b1000);
        chk("rep_lat_t1", 64'(rep_valid), 64'd0);
        recv("rep_first", w);
        chk("rep_first_lat", 64'(w), 64'd1);

        // Three-channel burst, records two cycles apart
        drv[0] = 32'h11; drv[1] = 32'h22; drv[2] = 32'h33;
        send_burst(4'b0111);
        for (int i = 0; i < 3; i++) begin
            recv("rep_burst", w);
            chk("rep_burst_gap", 64'(w), 64'd1);
        end

        // Stall: payload held while ready is low; new samples arrive meanwhile
        rep_ready = 1'b0;
        drv[1] = 32'h55;
        send_burst(4'b0010);
        step();
        chk("stall_valid", 64'(rep_valid), 64'd1);
        chk("stall_state", 64'(rep_state_dbg), 64'd1);
        drv[0] = 32'h66; drv[1] = 32'h99;
        send(4'b0011);
        for (int i = 0; i < 5; i++) begin
            chk("stall_hold", 64'({rep_valid, rep_ch, rep_data}), 64'({1'b1, 2'd1, 32'h55}));
            step();
        end
        exp_q.push_back({2'd0, 32'h66});
        exp_q.push_back({2'd1, 32'h99});
        for (int i = 0; i < 3; i++) recv("stall_drain", w);

        // Sample on the channel being granted in the same cycle
        drv[2] = 32'hAA;
        send(4'b0100);
        drv[2] = 32'hBB;
        send(4'b0100);
        exp_q.push_back({2'd2, 32'hAA});
        exp_q.push_back({2'd2, 32'hBB});
        recv("same_cycle_old", w);
        recv("same_cycle_new", w);

        // Staleness of the displayed channel
        mask = '0;
        mask[m_cur] = 1'b1;
        drv[m_cur] = $urandom;
        send_burst(mask);
        step();
        chk("stale_clear", 64'(disp_stale), 64'd0);
        chk("disp_data_lat", 64'(disp_data), 64'(m_samp[m_cur]));
        recv("stale_rec", w);
        tick_pulse();
        tick_pulse();
        chk("stale_2ticks", 64'(disp_stale), 64'd0);
        tick_pulse();
        chk("stale_3ticks", 64'(disp_stale), 64'(STALE_ON));

        // Randomized bursts with random back-pressure
        for (int it = 0; it < 25; it++) begin
            mask = 4'($urandom_range(1, 15));
            for (int k = 0; k < N_CH; k++) drv[k] = $urandom;
            send_burst(mask);
            cyc = 0;
            held = 1'b0;
            hold_rec = '0;
            while (exp_q.size() > 0 && cyc < 200) begin
                rep_ready = 1'($urandom_range(0, 1));
                if (rep_valid) begin
                    if (held) chk("rand_hold", 64'({rep_ch, rep_data}), 64'(hold_rec));
                    if (rep_ready) begin
                        rec = exp_q.pop_front();
                        chk("rand_rec", 64'({rep_ch, rep_data}), 64'(rec));
                        m_last = int'(rec[REC_W-1:DATA_W]);
                        held = 1'b0;
                        step();
                        chk("rand_gap", 64'(rep_valid), 64'd0);
                    end else begin
                        held = 1'b1;
                        hold_rec = {rep_ch, rep_data};
                        step();
                    end
                end else begin
                    held = 1'b0;
                    step();
                end
                cyc++;
            end
            chk("rand_drained", 64'(exp_q.size()), 64'd0);
            exp_q.delete();
        end

        // Randomized enable masks and buttons
        for (int it = 0; it < 30; it++) begin
            ch_en = 4'($urandom_range(1, 15));
            b = 2'($urandom_range(0, 3));
            pulse_btn(b[0], b[1]);
            chk("rand_disp_ch", 64'(disp_ch), 64'(m_cur));
            chk("rand_disp_data", 64'(disp_data), 64'(m_samp[m_cur]));
        end

        // Reset in the middle of a transfer drops record and pending bits
        ch_en = 4'b1111;
        rep_ready = 1'b0;
        drv[0] = 32'hDEAD; drv[2] = 32'hBEEF;
        send(4'b0101);
        step();
        chk("pre_rst_valid", 64'(rep_valid), 64'd1);
        rst = 1'b0;
        step();
        chk("rst_drop_valid", 64'(rep_valid), 64'd0);
        rst = 1'b1;
        rep_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rst_no_pend", 64'(rep_valid), 64'd0);
        end
        chk("rst_disp_ch2", 64'(disp_ch), 64'd0);
        chk("rst_disp_data2", 64'(disp_data), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
